led_pattern_player: RTL and testbench

//  Consumes the 16-bit random word from the LFSR stage and plays it back as an LED pattern for
//  one memory round. Requests a frozen random word via next_stage and latches it once
//  has_generated is seen. Splits the word into 4-bit LED indices and lights each LED one-hot
//  for a fixed time, with optional dark gaps. Sits between the LFSR and the LED pins.

---
 rtl/led_pattern_player.sv | 160 ++++++++++++++++
 tb/tb_led_pattern_player.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_player.sv
// Plays one frozen LFSR word back as a sequence of one-hot LED steps (MSB nibble first),
// with optional dark gaps between steps, then pulses done and returns to idle.
module led_pattern_player #(
    parameter int STEP_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  seq_len,
    input  logic [15:0] rand_in,
    input  logic        rand_valid,
    output logic        next_stage,
    output logic [15:0] led,
    output logic [15:0] pattern,
    output logic [2:0]  len_latched,
    output logic        busy,
    output logic        done
);

    localparam int CNT_MAX = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RNG,
        S_SHOW,
        S_GAP,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_step;
    logic [2:0]        r_len;
    logic [15:0]       r_pattern;
    logic [15:0]       r_led;
    logic              r_next;
    logic              r_busy;
    logic              r_done;

    logic              w_last_step;
    logic [1:0]        w_step_nxt;

    function automatic logic [2:0] clamp_len(input logic [2:0] n);
        if (n == 3'd0)
            return 3'd1;
        else if (n > 3'd4)
            return 3'd4;
        else
            return n;
    endfunction

    function automatic logic [15:0] led_for(input logic [15:0] w, input logic [1:0] s);
        logic [3:0] nib;
        case (s)
            2'd0:    nib = w[15:12];
            2'd1:    nib = w[11:8];
            2'd2:    nib = w[7:4];
            default: nib = w[3:0];
        endcase
        return 16'h1 << nib;
    endfunction

    assign w_last_step = ({1'b0, r_step} == (r_len - 3'd1));
    assign w_step_nxt  = r_step + 2'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_step    <= 2'd0;
            r_len     <= 3'd0;
            r_pattern <= 16'h0;
            r_led     <= 16'h0;
            r_next    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_led <= 16'h0;
                    if (start) begin
                        r_len   <= clamp_len(seq_len);
                        r_next  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT_RNG;
                    end
                end
                S_WAIT_RNG: begin
                    if (rand_valid) begin
                        r_pattern <= rand_in;
                        r_step    <= 2'd0;
                        r_cnt     <= '0;
                        r_led     <= led_for(rand_in, 2'd0);
                        r_state   <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (r_cnt == STEP_LAST) begin
                        r_cnt <= '0;
                        if (GAP_CYCLES > 0) begin
                            r_led   <= 16'h0;
                            r_state <= S_GAP;
                        end else if (w_last_step) begin
                            r_led   <= 16'h0;
                            r_busy  <= 1'b0;
                            r_next  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_step  <= w_step_nxt;
                            r_led   <= led_for(r_pattern, w_step_nxt);
                            r_state <= S_SHOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_GAP: begin
                    // The step-advance decision happens on the last dark edge, so no extra cycle.
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (w_last_step) begin
                            r_busy  <= 1'b0;
                            r_next  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_step  <= w_step_nxt;
                            r_led   <= led_for(r_pattern, w_step_nxt);
                            r_state <= S_SHOW;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_led   <= 16'h0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign next_stage  = r_next;
    assign led         = r_led;
    assign pattern     = r_pattern;
    assign len_latched = r_len;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_led_pattern_player.sv
// Directed bench: two instances (gap of 2 and no gap) share inputs; rounds come from a
// vector table, with hand sequences for reset and idle checks.
module tb_led_pattern_player;

    localparam int S = 4;
    localparam int G = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  seq_len;
    logic [15:0] rand_in;
    logic        rand_valid;

    logic        next_a, busy_a, done_a, next_b, busy_b, done_b;
    logic [15:0] led_a, pat_a, led_b, pat_b;
    logic [2:0]  len_a, len_b;

    logic        sel;
    logic        cur_next, cur_busy, cur_done;
    logic [15:0] cur_led, cur_pat;
    logic [2:0]  cur_len;

    int total = 0;
    int bad   = 0;

    led_pattern_player #(.STEP_CYCLES(S), .GAP_CYCLES(G)) dut_a (
        .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .rand_in(rand_in),
        .rand_valid(rand_valid), .next_stage(next_a), .led(led_a), .pattern(pat_a),
        .len_latched(len_a), .busy(busy_a), .done(done_a)
    );

    led_pattern_player #(.STEP_CYCLES(S), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .rand_in(rand_in),
        .rand_valid(rand_valid), .next_stage(next_b), .led(led_b), .pattern(pat_b),
        .len_latched(len_b), .busy(busy_b), .done(done_b)
    );

    always #5 clk = ~clk;

    always_comb begin
        cur_next = sel ? next_b : next_a;
        cur_busy = sel ? busy_b : busy_a;
        cur_done = sel ? done_b : done_a;
        cur_led  = sel ? led_b  : led_a;
        cur_pat  = sel ? pat_b  : pat_a;
        cur_len  = sel ? len_b  : len_a;
    end

    typedef struct {
        logic             sel;
        logic [2:0]       slen;
        logic [15:0]      rin;
        logic [2:0]       elen;
        logic [0:3][15:0] eled;
        logic             early;
        logic             poke;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [2:0] sl, input logic [15:0] rin,
                                input logic [2:0] el, input logic [15:0] l0, input logic [15:0] l1,
                                input logic [15:0] l2, input logic [15:0] l3,
                                input logic e, input logic p);
        vec_t v;
        v.sel = s; v.slen = sl; v.rin = rin; v.elen = el;
        v.eled = {l0, l1, l2, l3};
        v.early = e; v.poke = p;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        rand_valid = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 300 && (busy_a || busy_b); i++) tick();
        check("idle_wait", 16'({busy_a, busy_b}), 16'h0);
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int g;
        int n;
        int stp;
        int p;
        logic [15:0] exp;
        g = v.sel ? 0 : G;
        n = int'(v.elen) * (S + g);
        sel = v.sel;
        start = 1'b1;
        seq_len = v.slen;
        rand_in = v.rin;
        rand_valid = v.early;
        tick();
        start = 1'b0;
        check("wait_flags", 16'({cur_done, cur_busy, cur_next}), 16'h3);
        check("wait_len", 16'(cur_len), 16'(v.elen));
        check("wait_led", cur_led, 16'h0);
        rand_valid = 1'b1;
        seq_len = ~v.slen;
        tick();
        for (int k = 0; k < n; k++) begin
            stp = k / (S + g);
            p = k % (S + g);
            exp = (p < S) ? v.eled[stp] : 16'h0;
            check("led", cur_led, exp);
            check("run_flags", 16'({cur_done, cur_busy, cur_next}), 16'h3);
            check("pattern", cur_pat, v.rin);
            rand_in = ~rand_in;
            start = (v.poke && k == 1);
            tick();
        end
        check("done_flags", 16'({cur_done, cur_busy, cur_next}), 16'h4);
        check("done_led", cur_led, 16'h0);
        check("done_pattern", cur_pat, v.rin);
        start = v.poke;
        tick();
        check("after_done", 16'({cur_done, cur_busy, cur_next}), 16'h0);
        if (v.poke) begin
            tick();
            check("restart_busy", 16'({cur_busy, cur_next}), 16'h3);
            start = 1'b0;
        end
        wait_idle();
    endtask

    initial begin
        tbl[0] = mk(1'b0, 3'd4, 16'hACE1, 3'd4, 16'h0400, 16'h1000, 16'h4000, 16'h0002, 1'b0, 1'b0);
        tbl[1] = mk(1'b0, 3'd0, 16'hACE1, 3'd1, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        tbl[2] = mk(1'b0, 3'd7, 16'hACE1, 3'd4, 16'h0400, 16'h1000, 16'h4000, 16'h0002, 1'b0, 1'b1);
        tbl[3] = mk(1'b1, 3'd4, 16'h0F37, 3'd4, 16'h0001, 16'h8000, 16'h0008, 16'h0080, 1'b0, 1'b0);
        tbl[4] = mk(1'b0, 3'd3, 16'h1234, 3'd3, 16'h0002, 16'h0004, 16'h0008, 16'h0000, 1'b1, 1'b0);
        tbl[5] = mk(1'b1, 3'd5, 16'h5A3C, 3'd4, 16'h0020, 16'h0400, 16'h0008, 16'h1000, 1'b0, 1'b0);
        tbl[6] = mk(1'b1, 3'd2, 16'h0F37, 3'd2, 16'h0001, 16'h8000, 16'h0000, 16'h0000, 1'b0, 1'b0);

        sel = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        seq_len = 3'd0;
        rand_in = 16'h0;
        rand_valid = 1'b0;
        tick();
        tick();
        check("rst_led", led_a, 16'h0);
        check("rst_pattern", pat_a, 16'h0);
        check("rst_flags", 16'({done_a, busy_a, next_a}), 16'h0);
        check("rst_len", 16'(len_a), 16'h0);
        rst = 1'b0;
        tick();
        check("idle_flags", 16'({done_a, busy_a, next_a, done_b, busy_b, next_b}), 16'h0);

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // reset in the second SHOW step
        sel = 1'b0;
        start = 1'b1;
        seq_len = 3'd4;
        rand_in = 16'hACE1;
        rand_valid = 1'b0;
        tick();
        start = 1'b0;
        rand_valid = 1'b1;
        tick();
        for (int k = 0; k < S + G + 1; k++) tick();
        check("pre_rst_led", led_a, 16'h1000);
        rst = 1'b1;
        #1;
        check("async_led", led_a, 16'h0);
        check("async_flags", 16'({done_a, busy_a, next_a}), 16'h0);
        check("async_pattern", pat_a, 16'h0);
        check("async_len", 16'(len_a), 16'h0);
        tick();
        rst = 1'b0;
        rand_valid = 1'b0;
        tick();
        check("post_rst_flags", 16'({done_a, busy_a, next_a}), 16'h0);
        check("post_rst_led", led_a, 16'h0);

        run_vec(tbl[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
